multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control unit for the multicycle ARM core: the stateful successor to the single-cycle decoder. It sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states per instruction and holds the NZCV flag register and condition-check logic. It also stalls on a memory ready handshake and generates per-lane byte enables for a parametrised memory word width. It sits between the instruction register/flag outputs of the datapath and all datapath mux selects and write strobes.

## Interface
- BYTE_LANES, 4, byte lanes per memory word (power of two, ≥2); ByteEnable width
- LANE_W, $clog2(BYTE_LANES), width of ByteAddr
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- Rd  in  4  Instr[15:12]
- Src2  in  12  Instr[11:0]
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- ByteAddr  in  LANE_W  low address bits of current memory access
- MemReady  in  1  memory completes access this cycle
- PCWrite, IRWrite, RegW, MemW  out  1 each  write strobes
- AdrSrc  out  1  0=PC, 1=ALU result register
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=RD2/shifted, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALUResult
- ImmSrc, RegSrc  out  2 each  extender mode / register-address selects
- ALUControl  out  4  ARM data-processing opcode encoding
- ByteEnable  out  BYTE_LANES  lane write/read enables
- BranchLink  out  1  BL: write R14 this cycle
- Flags  out  4  registered NZCV
- InstrDone  out  1  one-cycle pulse, instruction retired
- UndefInstr  out  1  one-cycle pulse, Op=11 seen in DECODE

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=0100, ResultSrc=10. IRWrite and PCWrite equal MemReady. Stay until MemReady, then DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Register CondEx from Cond against Flags (all 15 ARM codes; 1111 treated as never).
- DECODE transitions:
  - CondEx=0 → FETCH with InstrDone.
  - Otherwise Op=00 → EXECR if Funct[5]=0, EXECI if Funct[5]=1.
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=11 → FETCH with UndefInstr=1 and InstrDone=1.
- MEMADR: ALUSrcA=0, ALUSrcB=01 if Funct[5]=0 else 00. ALUControl=0100 if Funct[3] (U) else 0010. Next MEMRD if Funct[0]=1, else MEMWR.
- MEMRD: AdrSrc=1. Stay until MemReady, then MEMWB.
- MEMWB: ResultSrc=01, RegW=1, PCWrite=(Rd==15), InstrDone → FETCH.
- MEMWR: AdrSrc=1, MemW=1. Stay until MemReady, then FETCH with InstrDone.
- EXECR/EXECI: ALUSrcA=0, ALUSrcB=00/01, ALUControl=Funct[4:1].
  - NoWrite=(Funct[4:3]==10) & ~(Src2[7]&Src2[4]).
  - NoWrite → FETCH with InstrDone; else ALUWB.
- ALUWB: ResultSrc=00, RegW=1, PCWrite=(Rd==15), InstrDone → FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=0100, ResultSrc=10, PCWrite=1. RegW=BranchLink=Funct[4]. InstrDone → FETCH.
- Flag write (EXEC states, S=Funct[0]=1):
  - Flags[3:2] (NZ) always written.
  - Flags[1:0] (CV) written only for arithmetic opcodes 0010,0011,0100,0101,0110,0111,1010,1011.
  - Logical ops keep C,V.
- ImmSrc: 00 data-processing, 01 memory, 10 branch. RegSrc: 00 data-processing/LDR, 10 STR, 01 branch.
- ByteEnable, in MEMRD/MEMWR only, 0 elsewhere:
  - Funct[2]=1 (byte access): one-hot bit ByteAddr.
  - Otherwise all ones.
- Outputs not listed for a state are 0.

## Timing
- reset high at a clock edge: state←FETCH, Flags←0000, CondEx←0.
- While reset is high, PCWrite, IRWrite, RegW, MemW, InstrDone and UndefInstr are forced 0; other outputs are don't-care.
- reset mid-instruction (any state, including a MemReady stall) aborts with no further strobes.
- Flags update on the edge ending EXECR/EXECI. The new value is visible to the next instruction's DECODE.
- Minimum cycles with MemReady tied high:
  - B/BL: 3.
  - Data-processing: 4 (3 if NoWrite).
  - STR: 4.
  - LDR: 5.
  - Instruction with failed condition: 2.
- Each cycle MemReady=0 in FETCH/MEMRD/MEMWR adds one cycle. Strobes stay asserted (MemW) or suppressed (IRWrite/PCWrite) throughout.
- All outputs are combinational from state and inputs, with Flags and CondEx registered; no output-side latency.

## Test plan
- ADDS R1,R2,#5 (Cond=1110, Op=00, Funct=101001, Rd=1), MemReady=1, ALUFlags=0110 → FETCH,DECODE,EXECI,ALUWB. RegW=1 only in ALUWB. Flags=0110 after EXECI. InstrDone in ALUWB.
- Flags=0100; ANDS with ALUFlags=1000 → Flags=1000 with C,V unchanged at 00. Then CMP (Funct=010101), ALUFlags=0010 → FETCH after EXECR, no RegW, Flags=0010.
- LDRB (Op=01, Funct=010101), BYTE_LANES=4, ByteAddr=2, MemReady low 3 cycles in MEMRD → ByteEnable=0100 for 4 MEMRD cycles. Then MEMWB with RegW=1, ResultSrc=01.
- BEQ (Cond=0000) with Flags Z=0 → FETCH after DECODE, no PCWrite outside FETCH, InstrDone pulse. BL (Funct[4]=1), Cond=1110 → BRANCH asserts PCWrite=1, RegW=1, BranchLink=1.
- Op=11 → UndefInstr=1 and InstrDone=1 in DECODE, next state FETCH. Reset asserted during a MEMWR stall → MemW=0 from that cycle, FETCH, Flags=0000.
- BYTE_LANES=8 build: STRB with ByteAddr=7 → ByteEnable=10000000. STR (Funct[2]=0) → ByteEnable=11111111.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM control unit for the multicycle ARM core with NZCV flags,
// condition checking, memory-ready stalls and per-lane byte enables.
module multicycle_controller #(
    parameter int BYTE_LANES = 4,
    parameter int LANE_W     = $clog2(BYTE_LANES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            Cond,
    input  logic [1:0]            Op,
    input  logic [5:0]            Funct,
    input  logic [3:0]            Rd,
    input  logic [11:0]           Src2,
    input  logic [3:0]            ALUFlags,
    input  logic [LANE_W-1:0]     ByteAddr,
    input  logic                  MemReady,
    output logic                  PCWrite,
    output logic                  IRWrite,
    output logic                  RegW,
    output logic                  MemW,
    output logic                  AdrSrc,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ImmSrc,
    output logic [1:0]            RegSrc,
    output logic [3:0]            ALUControl,
    output logic [BYTE_LANES-1:0] ByteEnable,
    output logic                  BranchLink,
    output logic [3:0]            Flags,
    output logic                  InstrDone,
    output logic                  UndefInstr
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    state_t state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic cond_ex_q, cond_ex_d;
    logic cond_ok, arith, no_write, n, z, c, v;
    logic [BYTE_LANES-1:0] be_sel;
    logic unused;

    assign unused = ^{Src2[11:8], Src2[6:5], Src2[3:0]};
    assign {n, z, c, v} = flags_q;
    assign Flags = flags_q;
    assign arith = Funct[4:1] inside {4'b0010, 4'b0011, 4'b0100, 4'b0101,
                                      4'b0110, 4'b0111, 4'b1010, 4'b1011};
    // Compare/test ops skip writeback unless Src2 encodes a multiply-style extension
    assign no_write = (Funct[4:3] == 2'b10) & ~(Src2[7] & Src2[4]);
    assign be_sel = Funct[2] ? (BYTE_LANES'(1) << ByteAddr) : '1;
    assign cond_ex_d = (state_q == S_DECODE) ? cond_ok : cond_ex_q;

    always_comb begin
        case (Cond)
            4'b0000: cond_ok = z;
            4'b0001: cond_ok = ~z;
            4'b0010: cond_ok = c;
            4'b0011: cond_ok = ~c;
            4'b0100: cond_ok = n;
            4'b0101: cond_ok = ~n;
            4'b0110: cond_ok = v;
            4'b0111: cond_ok = ~v;
            4'b1000: cond_ok = c & ~z;
            4'b1001: cond_ok = ~c | z;
            4'b1010: cond_ok = n == v;
            4'b1011: cond_ok = n != v;
            4'b1100: cond_ok = ~z & (n == v);
            4'b1101: cond_ok = z | (n != v);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if ((state_q == S_EXECR || state_q == S_EXECI) && Funct[0] && cond_ex_q) begin
            flags_d[3:2] = ALUFlags[3:2];
            if (arith) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            flags_q   <= '0;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 4'b0000;
        ByteEnable = '0;
        BranchLink = 1'b0;
        InstrDone  = 1'b0;
        UndefInstr = 1'b0;
        ImmSrc     = (Op == 2'b01) ? 2'b01 : (Op == 2'b10) ? 2'b10 : 2'b00;
        RegSrc     = (Op == 2'b10) ? 2'b01 : (Op == 2'b01 && !Funct[0]) ? 2'b10 : 2'b00;
        state_d    = state_q;
        case (state_q)
            S_FETCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 4'b0100;
                ResultSrc  = 2'b10;
                IRWrite    = MemReady;
                PCWrite    = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (!cond_ok || Op == 2'b11) begin
                    InstrDone  = 1'b1;
                    UndefInstr = cond_ok;
                    state_d    = S_FETCH;
                end else begin
                    state_d = (Op == 2'b01) ? S_MEMADR : (Op == 2'b10) ? S_BRANCH :
                              Funct[5] ? S_EXECI : S_EXECR;
                end
            end
            S_MEMADR: begin
                ALUSrcB    = Funct[5] ? 2'b00 : 2'b01;
                ALUControl = Funct[3] ? 4'b0100 : 4'b0010;
                state_d    = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc     = 1'b1;
                ByteEnable = be_sel;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                PCWrite   = Rd == 4'd15;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc     = 1'b1;
                MemW       = 1'b1;
                ByteEnable = be_sel;
                InstrDone  = MemReady;
                if (MemReady) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                ALUControl = Funct[4:1];
                InstrDone  = no_write;
                state_d    = no_write ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                RegW      = 1'b1;
                PCWrite   = Rd == 4'd15;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB    = 2'b01;
                ALUControl = 4'b0100;
                ResultSrc  = 2'b10;
                PCWrite    = 1'b1;
                RegW       = Funct[4];
                BranchLink = Funct[4];
                InstrDone  = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (reset) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            RegW       = 1'b0;
            MemW       = 1'b0;
            InstrDone  = 1'b0;
            UndefInstr = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and randomized checks of the multicycle controller
// (4-lane and 8-lane builds) against a phase-list behavioural model.
module tb_multicycle_controller;
    localparam int F = 0, D = 1, MA = 2, MR = 3, MB = 4, MW = 5, EX = 6, AW = 7, BR = 8;

    logic clk = 1'b0, reset = 1'b1;
    logic [3:0] Cond = '0, Rd = '0, ALUFlags = '0;
    logic [1:0] Op = '0;
    logic [5:0] Funct = '0;
    logic [11:0] Src2 = '0;
    logic [2:0] ba8 = '0;
    logic MemReady = 1'b0;

    logic PCWrite, IRWrite, RegW, MemW, AdrSrc, ALUSrcA, BranchLink, InstrDone, UndefInstr;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [3:0] ALUControl, Flags, ByteEnable;
    logic PCWrite8, IRWrite8, RegW8, MemW8, AdrSrc8, ALUSrcA8, BranchLink8, InstrDone8, UndefInstr8;
    logic [1:0] ALUSrcB8, ResultSrc8, ImmSrc8, RegSrc8;
    logic [3:0] ALUControl8, Flags8;
    logic [7:0] ByteEnable8;

    int checks = 0, errors = 0;
    int ph = F;
    int q[$];
    logic [3:0] mfl = '0;

    always #5 clk = ~clk;

    multicycle_controller #(.BYTE_LANES(4)) u4 (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd), .Src2(Src2),
        .ALUFlags(ALUFlags), .ByteAddr(ba8[1:0]), .MemReady(MemReady),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegW(RegW), .MemW(MemW), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .ALUControl(ALUControl), .ByteEnable(ByteEnable),
        .BranchLink(BranchLink), .Flags(Flags), .InstrDone(InstrDone), .UndefInstr(UndefInstr));

    multicycle_controller #(.BYTE_LANES(8)) u8 (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd), .Src2(Src2),
        .ALUFlags(ALUFlags), .ByteAddr(ba8), .MemReady(MemReady),
        .PCWrite(PCWrite8), .IRWrite(IRWrite8), .RegW(RegW8), .MemW(MemW8), .AdrSrc(AdrSrc8),
        .ALUSrcA(ALUSrcA8), .ALUSrcB(ALUSrcB8), .ResultSrc(ResultSrc8), .ImmSrc(ImmSrc8),
        .RegSrc(RegSrc8), .ALUControl(ALUControl8), .ByteEnable(ByteEnable8),
        .BranchLink(BranchLink8), .Flags(Flags8), .InstrDone(InstrDone8), .UndefInstr(UndefInstr8));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ARM condition: base test picked by Cond[3:1], inverted by Cond[0]; 1111 never.
    function automatic logic pass(input logic [3:0] cd, input logic [3:0] fl);
        logic r;
        case (cd[3:1])
            3'd0: r = fl[2];
            3'd1: r = fl[1];
            3'd2: r = fl[3];
            3'd3: r = fl[0];
            3'd4: r = fl[1] & ~fl[2];
            3'd5: r = fl[3] == fl[0];
            3'd6: r = ~fl[2] & (fl[3] == fl[0]);
            default: r = 1'b1;
        endcase
        return (cd == 4'hf) ? 1'b0 : (cd[0] ? ~r : r);
    endfunction

    task automatic step();
        logic pcw, irw, rw, mw, as, sa, bl, dn, un, ben, nowr;
        logic [1:0] sb, rs, is, rsrc;
        logic [3:0] ac, be4;
        logic [7:0] be8;
        @(negedge clk);
        {pcw, irw, rw, mw, as, sa, bl, dn, un, ben} = '0;
        sb = 0; rs = 0; ac = 0;
        nowr = Funct[4:3] == 2'b10 && !(Src2[7] && Src2[4]);
        is = Op == 1 ? 2'd1 : Op == 2 ? 2'd2 : 2'd0;
        rsrc = Op == 2 ? 2'd1 : (Op == 1 && !Funct[0]) ? 2'd2 : 2'd0;
        case (ph)
            F: begin sa = 1; sb = 2; ac = 4; rs = 2; irw = MemReady; pcw = MemReady; end
            D: begin
                sa = 1; sb = 2; rs = 2;
                dn = !pass(Cond, mfl) || Op == 3;
                un = pass(Cond, mfl) && Op == 3;
            end
            MA: begin sb = Funct[5] ? 2'd0 : 2'd1; ac = Funct[3] ? 4'd4 : 4'd2; end
            MR: begin as = 1; ben = 1; end
            MB: begin rs = 1; rw = 1; pcw = Rd == 15; dn = 1; end
            MW: begin as = 1; mw = 1; ben = 1; dn = MemReady; end
            EX: begin sb = Funct[5] ? 2'd1 : 2'd0; ac = Funct[4:1]; dn = nowr; end
            AW: begin rw = 1; pcw = Rd == 15; dn = 1; end
            default: begin sb = 1; ac = 4; rs = 2; pcw = 1; rw = Funct[4]; bl = Funct[4]; dn = 1; end
        endcase
        be4 = !ben ? 4'h0 : Funct[2] ? (4'b0001 << ba8[1:0]) : 4'hf;
        be8 = !ben ? 8'h0 : Funct[2] ? (8'b00000001 << ba8) : 8'hff;
        if (reset) {pcw, irw, rw, mw, dn, un} = '0;
        chk("PCWrite", PCWrite, pcw);
        chk("IRWrite", IRWrite, irw);
        chk("RegW", RegW, rw);
        chk("MemW", MemW, mw);
        chk("InstrDone", InstrDone, dn);
        chk("UndefInstr", UndefInstr, un);
        chk("Flags", Flags, mfl);
        chk("MemW8", MemW8, mw);
        chk("InstrDone8", InstrDone8, dn);
        chk("Flags8", Flags8, mfl);
        if (!reset) begin
            chk("AdrSrc", AdrSrc, as);
            chk("ALUSrcA", ALUSrcA, sa);
            chk("ALUSrcB", ALUSrcB, sb);
            chk("ResultSrc", ResultSrc, rs);
            chk("ImmSrc", ImmSrc, is);
            chk("RegSrc", RegSrc, rsrc);
            chk("ALUControl", ALUControl, ac);
            chk("BranchLink", BranchLink, bl);
            chk("ByteEnable", ByteEnable, be4);
            chk("ByteEnable8", ByteEnable8, be8);
        end
        @(posedge clk);
        if (reset) begin
            ph = F; q.delete(); mfl = '0;
        end else begin
            if (ph == EX && Funct[0]) begin
                mfl[3:2] = ALUFlags[3:2];
                if ((Funct[4:1] >= 2 && Funct[4:1] <= 7) || Funct[4:1] == 10 || Funct[4:1] == 11)
                    mfl[1:0] = ALUFlags[1:0];
            end
            case (ph)
                F: if (MemReady) ph = D;
                D: begin
                    if (!pass(Cond, mfl) || Op == 3) ph = F;
                    else begin
                        if (Op == 0) begin q.push_back(EX); if (!nowr) q.push_back(AW); end
                        else if (Op == 1) begin
                            q.push_back(MA);
                            q.push_back(Funct[0] ? MR : MW);
                            if (Funct[0]) q.push_back(MB);
                        end else q.push_back(BR);
                        ph = q.pop_front();
                    end
                end
                MR, MW: if (MemReady) ph = (q.size() > 0) ? q.pop_front() : F;
                default: ph = (q.size() > 0) ? q.pop_front() : F;
            endcase
        end
        #1;
    endtask

    task automatic ins(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input logic [11:0] s);
        Cond = c; Op = o; Funct = f; Rd = r; Src2 = s;
    endtask

    task automatic drv(input logic [3:0] af, input logic [2:0] b, input logic m);
        ALUFlags = af; ba8 = b; MemReady = m;
        #2;
    endtask

    task automatic cyc(input logic [3:0] af, input logic [2:0] b, input logic m);
        drv(af, b, m);
        step();
    endtask

    initial begin
        drv(0, 0, 1);
        chk("rst_pcw", PCWrite, 0);
        step(); step();
        chk("rst_flags", Flags, 0);
        reset = 0;
        // ADDS R1,R2,#5
        ins(4'he, 0, 6'b101001, 1, 5);
        drv(6, 0, 1); chk("adds_f_irw", IRWrite, 1); step();
        drv(6, 0, 1); chk("adds_d_regw", RegW, 0); step();
        drv(6, 0, 1); chk("adds_x_srcb", ALUSrcB, 1); chk("adds_x_regw", RegW, 0); step();
        chk("adds_flags", Flags, 4'b0110);
        drv(6, 0, 1); chk("adds_wb_regw", RegW, 1); chk("adds_wb_done", InstrDone, 1); step();
        for (int i = 0; i < 4; i++) cyc(4'b0100, 0, 1);
        chk("adds2_flags", Flags, 4'b0100);
        // ANDS keeps C,V even though ALU reports them set
        ins(4'he, 0, 6'b000001, 2, 0);
        for (int i = 0; i < 4; i++) cyc(4'b1011, 0, 1);
        chk("ands_flags", Flags, 4'b1000);
        // CMP: no writeback, retires in EXECR
        ins(4'he, 0, 6'b010101, 0, 0);
        cyc(2, 0, 1); cyc(2, 0, 1);
        drv(2, 0, 1); chk("cmp_done", InstrDone, 1); chk("cmp_regw", RegW, 0); step();
        chk("cmp_flags", Flags, 4'b0010);
        // LDRB, ByteAddr=2, three-cycle stall in MEMRD
        ins(4'he, 1, 6'b010101, 3, 0);
        cyc(0, 2, 1); cyc(0, 2, 1);
        drv(0, 2, 1); chk("ldrb_aluc", ALUControl, 4'b0010); step();
        for (int i = 0; i < 4; i++) begin
            drv(0, 2, i == 3);
            chk("ldrb_be", ByteEnable, 4'b0100);
            chk("ldrb_be8", ByteEnable8, 8'b00000100);
            step();
        end
        drv(0, 2, 1); chk("ldrb_regw", RegW, 1); chk("ldrb_res", ResultSrc, 1); step();
        // BEQ with Z=0 fails its condition
        ins(4'h0, 2, 6'b000000, 0, 0);
        cyc(0, 0, 1);
        drv(0, 0, 1); chk("beq_done", InstrDone, 1); chk("beq_pcw", PCWrite, 0); step();
        // BL
        ins(4'he, 2, 6'b010000, 0, 0);
        cyc(0, 0, 1); cyc(0, 0, 1);
        drv(0, 0, 1); chk("bl_pcw", PCWrite, 1); chk("bl_regw", RegW, 1); chk("bl_link", BranchLink, 1); step();
        // Undefined Op=11
        ins(4'he, 3, 6'b000000, 0, 0);
        cyc(0, 0, 1);
        drv(0, 0, 1); chk("undef", UndefInstr, 1); chk("undef_done", InstrDone, 1); step();
        drv(0, 0, 1); chk("undef_next_irw", IRWrite, 1); step();
        cyc(0, 0, 1);
        // STRB at lane 7
        ins(4'he, 1, 6'b011100, 0, 0);
        cyc(0, 7, 1); cyc(0, 7, 1);
        drv(0, 7, 1); chk("strb_aluc", ALUControl, 4'b0100); step();
        drv(0, 7, 1); chk("strb_be8", ByteEnable8, 8'h80); chk("strb_be4", ByteEnable, 4'b1000);
        chk("strb_memw", MemW, 1); step();
        // STR, reset during a MEMWR stall
        ins(4'he, 1, 6'b011000, 0, 0);
        cyc(0, 1, 1); cyc(0, 1, 1); cyc(0, 1, 1);
        drv(0, 1, 0); chk("str_be8", ByteEnable8, 8'hff); chk("str_memw", MemW, 1); step();
        reset = 1;
        drv(0, 1, 0); chk("rst_memw", MemW, 0); step();
        reset = 0;
        chk("rst_flags2", Flags, 0);
        drv(0, 0, 1); chk("rst_fetch_irw", IRWrite, 1); step();
        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            if (ph == F)
                ins($urandom_range(0, 1) ? 4'he : 4'($urandom), 2'($urandom), 6'($urandom),
                    4'($urandom), 12'($urandom));
            reset = $urandom_range(0, 199) == 0;
            cyc(4'($urandom), 3'($urandom), $urandom_range(0, 3) != 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
